fault_confinement_ctrl: RTL and testbench

FAULT_CONFINEMENT_CTRL -- requirements
Module: fault_confinement_ctrl

---
 rtl/can_fc_pkg.sv | 12 +
 rtl/fault_confinement_ctrl_if.sv | 22 ++
 rtl/busoff_recovery_counter.sv | 35 +++
 rtl/fault_confinement_ctrl.sv | 101 ++++++++++
 tb/tb_fault_confinement_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/can_fc_pkg.sv
// can_fc_pkg: shared encodings and thresholds for CAN fault confinement
// Exports: err_state_e (ERR_STATE encoding), req_state_e (request FSM states),
//          counter thresholds (passive 127, bus-off 256) and the 119 REC reload.
package can_fc_pkg;
   typedef enum logic [1:0] {ES_ACTIVE = 2'b00, ES_PASSIVE = 2'b01, ES_BUSOFF = 2'b10} err_state_e;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} req_state_e;
   localparam logic [8:0] TEC_BUSOFF  = 9'd256;
   localparam logic [8:0] TEC_CLAMP   = 9'd248;
   localparam logic [8:0] TEC_PASSIVE = 9'd127;
   localparam logic [7:0] REC_PASSIVE = 8'd127;
   localparam logic [7:0] REC_RELOAD  = 8'd119;
endpackage

// File: rtl/fault_confinement_ctrl_if.sv
// fault_confinement_ctrl_if: bus-side strobes and status of the fault confinement block
// master: drives rx, error/OK strobes, tx_mode, ovrld_req, f_itmss; reads status.
// slave:  the controller; drives f_ovrld, flag_passive, tec, rec, err_state, bus_off.
interface fault_confinement_ctrl_if;
   import can_fc_pkg::*;
   logic       rx, bit_err, stuff_err, crc_err, form_err, ack_err;
   logic       tx_mode, tx_ok, rx_ok, ovrld_req, f_itmss;
   logic       f_ovrld, flag_passive, bus_off;
   logic [8:0] tec;
   logic [7:0] rec;
   err_state_e err_state;
   modport master (
      output rx, bit_err, stuff_err, crc_err, form_err, ack_err,
      output tx_mode, tx_ok, rx_ok, ovrld_req, f_itmss,
      input  f_ovrld, flag_passive, tec, rec, err_state, bus_off
   );
   modport slave (
      input  rx, bit_err, stuff_err, crc_err, form_err, ack_err,
      input  tx_mode, tx_ok, rx_ok, ovrld_req, f_itmss,
      output f_ovrld, flag_passive, tec, rec, err_state, bus_off
   );
endinterface

// File: rtl/busoff_recovery_counter.sv
// busoff_recovery_counter: counts runs of IDLE_BITS recessive samples while bus-off
// Ports: sp_i clock, reset_i async reset, en_i (node is bus-off), rx_i bus level,
//        done_o one-cycle pulse on the edge that completes BUSOFF_SEQ runs.
module busoff_recovery_counter #(
   parameter int IDLE_BITS  = 11,
   parameter int BUSOFF_SEQ = 128
) (
   input  logic sp_i,
   input  logic reset_i,
   input  logic en_i,
   input  logic rx_i,
   output logic done_o
);
   localparam int RW = $clog2(IDLE_BITS + 1);
   localparam int SW = $clog2(BUSOFF_SEQ + 1);
   logic [RW-1:0] run_q, run_d;
   logic [SW-1:0] seq_q, seq_d;
   logic          run_last;
   assign run_last = run_q == RW'(IDLE_BITS - 1);
   assign done_o   = en_i & rx_i & run_last & (seq_q == SW'(BUSOFF_SEQ - 1));
   always_comb begin
      // a dominant sample discards the partial run; a completed run bumps the sequence count
      run_d = (!en_i || !rx_i || run_last) ? '0 : run_q + 1'b1;
      seq_d = (!en_i || done_o) ? '0 : (rx_i && run_last) ? seq_q + 1'b1 : seq_q;
   end
   always_ff @(posedge sp_i or posedge reset_i) begin
      if (reset_i) begin
         run_q <= '0;
         seq_q <= '0;
      end else begin
         run_q <= run_d;
         seq_q <= seq_d;
      end
   end
endmodule

// File: rtl/fault_confinement_ctrl.sv
// fault_confinement_ctrl: CAN TEC/REC bookkeeping, error state and overload/error flag requests
// Ports: sp_i bit-sample-point clock, reset_i async active-high reset,
//        bus (slave modport) carrying strobes in and counters/state/request out.
module fault_confinement_ctrl
   import can_fc_pkg::*;
#(
   parameter int IDLE_BITS  = 11,
   parameter int BUSOFF_SEQ = 128,
   parameter int WAIT_MAX   = 64
) (
   input logic                      sp_i,
   input logic                      reset_i,
   fault_confinement_ctrl_if.slave  bus
);
   localparam int WW = $clog2(WAIT_MAX + 1);
   logic [8:0]    tec_q, tec_d;
   logic [7:0]    rec_q, rec_d;
   err_state_e    es_q, es_d;
   req_state_e    st_q, st_d;
   logic          flag_q, flag_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic          busoff, err, ack_only, req_v, done;
   assign busoff   = es_q == ES_BUSOFF;
   assign err      = ~busoff & (bus.bit_err | bus.stuff_err | bus.crc_err | bus.form_err | bus.ack_err);
   assign ack_only = bus.ack_err & ~(bus.bit_err | bus.stuff_err | bus.crc_err | bus.form_err);
   assign req_v    = err | (bus.ovrld_req & ~busoff);
   busoff_recovery_counter #(.IDLE_BITS(IDLE_BITS), .BUSOFF_SEQ(BUSOFF_SEQ)) u_rec (
      .sp_i   (sp_i),
      .reset_i(reset_i),
      .en_i   (busoff),
      .rx_i   (bus.rx),
      .done_o (done)
   );
   always_comb begin
      tec_d = tec_q;
      rec_d = rec_q;
      if (done) begin
         tec_d = '0;
         rec_d = '0;
      end else if (err) begin
         // a lone ACK error while passive leaves TEC alone
         if (bus.tx_mode)
            tec_d = (ack_only && es_q == ES_PASSIVE) ? tec_q : (tec_q > TEC_CLAMP) ? TEC_BUSOFF : tec_q + 9'd8;
         else
            rec_d = (rec_q == 8'hff) ? rec_q : rec_q + 8'd1;
      end else if (!busoff) begin
         if (bus.tx_ok && tec_q != '0) tec_d = tec_q - 9'd1;
         if (bus.rx_ok) rec_d = (rec_q > REC_PASSIVE) ? REC_RELOAD : (rec_q != '0) ? rec_q - 8'd1 : rec_q;
      end
      // TEC only sits at 256 while bus-off, so the state follows straight from the next counts
      es_d = (tec_d == TEC_BUSOFF) ? ES_BUSOFF :
             (tec_d > TEC_PASSIVE || rec_d > REC_PASSIVE) ? ES_PASSIVE : ES_ACTIVE;
   end
   always_ff @(posedge sp_i or posedge reset_i) begin
      if (reset_i) begin
         tec_q  <= '0;
         rec_q  <= '0;
         es_q   <= ES_ACTIVE;
         st_q   <= ST_IDLE;
         flag_q <= 1'b0;
         wcnt_q <= '0;
      end else begin
         tec_q  <= tec_d;
         rec_q  <= rec_d;
         es_q   <= es_d;
         st_q   <= st_d;
         flag_q <= flag_d;
         wcnt_q <= wcnt_d;
      end
   end
   always_comb begin
      st_d   = st_q;
      flag_d = flag_q;
      wcnt_d = '0;
      if (es_d == ES_BUSOFF) st_d = ST_IDLE;
      else begin
         case (st_q)
            ST_IDLE: if (req_v) begin
               st_d   = ST_REQ;
               flag_d = err && es_d == ES_PASSIVE;
            end
            ST_REQ: st_d = ST_WAIT;
            ST_WAIT: begin
               if (!bus.f_itmss) st_d = ST_DRAIN;
               else if (wcnt_q == WW'(WAIT_MAX - 1)) st_d = ST_IDLE;
               else wcnt_d = wcnt_q + 1'b1;
            end
            ST_DRAIN: st_d = bus.f_itmss ? ST_IDLE : ST_DRAIN;
            default: st_d = ST_IDLE;
         endcase
      end
   end
   always_comb begin
      bus.f_ovrld      = st_q != ST_REQ;
      bus.flag_passive = flag_q;
      bus.tec          = tec_q;
      bus.rec          = rec_q;
      bus.err_state    = es_q;
      bus.bus_off      = busoff;
   end
endmodule

// File: tb/tb_fault_confinement_ctrl.sv
// tb_fault_confinement_ctrl: directed self-checking bench for fault_confinement_ctrl
module tb_fault_confinement_ctrl;
   logic sp = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   lows;
   logic flag15, flag16;

   fault_confinement_ctrl_if bus ();
   fault_confinement_ctrl dut (.sp_i(sp), .reset_i(reset), .bus(bus));

   always #5 sp = ~sp;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sp);
      #1;
   endtask

   task automatic clr();
      bus.bit_err = 0; bus.stuff_err = 0; bus.crc_err = 0; bus.form_err = 0; bus.ack_err = 0;
      bus.tx_ok = 0; bus.rx_ok = 0; bus.ovrld_req = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      clr();
      bus.f_itmss = 1;
      bus.rx = 0;
      bus.tx_mode = 0;
      tick();
      reset = 0;
   endtask

   initial begin
      clr();
      bus.rx = 0;
      bus.tx_mode = 0;
      bus.f_itmss = 1;
      #3;
      chk("rst_f_ovrld", bus.f_ovrld, 1);
      chk("rst_flag", bus.flag_passive, 0);
      chk("rst_tec", bus.tec, 0);
      chk("rst_rec", bus.rec, 0);
      chk("rst_state", bus.err_state, 0);
      chk("rst_bus_off", bus.bus_off, 0);
      tick();
      reset = 0;

      // first TX error: TEC 8, one-cycle request, active flag
      bus.tx_mode = 1; bus.bit_err = 1; tick(); clr();
      chk("tx_err_tec", bus.tec, 8);
      chk("tx_err_req", bus.f_ovrld, 0);
      chk("tx_err_flag", bus.flag_passive, 0);
      tick();
      chk("tx_err_wait", bus.f_ovrld, 1);
      bus.f_itmss = 0; tick(); bus.f_itmss = 1; tick();
      bus.tx_ok = 1; repeat (8) tick();
      chk("tx_ok_dec", bus.tec, 0);
      tick(); clr();
      chk("tx_ok_floor", bus.tec, 0);

      // 16 TX errors, each with a full handshake
      for (int i = 1; i <= 16; i++) begin
         bus.bit_err = 1; tick(); clr();
         chk("seq_req", bus.f_ovrld, 0);
         if (i == 15) flag15 = bus.flag_passive;
         if (i == 16) flag16 = bus.flag_passive;
         tick();
         bus.f_itmss = 0; tick(); bus.f_itmss = 1; tick();
      end
      chk("seq_tec", bus.tec, 128);
      chk("seq_state", bus.err_state, 1);
      chk("seq_flag15", flag15, 0);
      chk("seq_flag16", flag16, 1);

      // lone ACK error while passive: TEC holds, request still issued with passive flag
      bus.ack_err = 1; tick(); clr();
      chk("ack_passive_tec", bus.tec, 128);
      chk("ack_passive_req", bus.f_ovrld, 0);
      chk("ack_passive_flag", bus.flag_passive, 1);
      tick();
      bus.bit_err = 1; tick(); clr();
      chk("busy_err_tec", bus.tec, 136);
      chk("busy_err_noreq", bus.f_ovrld, 1);
      bus.f_itmss = 0; tick(); bus.f_itmss = 1; tick();
      bus.bit_err = 1; bus.form_err = 1; bus.tx_ok = 1; tick(); clr();
      chk("multi_err_tec", bus.tec, 144);

      // REC climb, reload to 119, error beats OK, saturation
      do_reset();
      bus.stuff_err = 1; repeat (130) tick(); clr();
      chk("rec_130", bus.rec, 130);
      chk("rec_130_state", bus.err_state, 1);
      bus.rx_ok = 1; tick(); clr();
      chk("rec_reload", bus.rec, 119);
      chk("rec_reload_state", bus.err_state, 0);
      bus.rx_ok = 1; bus.crc_err = 1; tick(); clr();
      chk("rec_err_wins", bus.rec, 120);
      bus.rx_ok = 1; tick(); clr();
      chk("rec_dec", bus.rec, 119);
      bus.stuff_err = 1; repeat (140) tick(); clr();
      chk("rec_sat", bus.rec, 255);

      // bus-off entry and recovery
      do_reset();
      bus.bit_err = 1; tick(); clr();
      bus.tx_mode = 1; bus.bit_err = 1; repeat (31) tick(); clr();
      chk("pre_busoff_tec", bus.tec, 248);
      chk("pre_busoff_state", bus.err_state, 1);
      bus.f_itmss = 0; tick(); bus.f_itmss = 1; tick();
      bus.bit_err = 1; tick(); clr();
      chk("busoff_tec", bus.tec, 256);
      chk("busoff_flag", bus.bus_off, 1);
      chk("busoff_state", bus.err_state, 2);
      chk("busoff_noreq", bus.f_ovrld, 1);
      chk("busoff_rec", bus.rec, 1);
      bus.bit_err = 1; bus.tx_ok = 1; bus.ovrld_req = 1; tick(); clr();
      chk("busoff_ign_tec", bus.tec, 256);
      chk("busoff_ign_rec", bus.rec, 1);
      chk("busoff_ign_req", bus.f_ovrld, 1);
      bus.rx = 1; repeat (5) tick();
      bus.rx = 0; tick();
      bus.rx = 1; repeat (1407) tick();
      chk("busoff_early", bus.bus_off, 1);
      tick();
      chk("recover_bus_off", bus.bus_off, 0);
      chk("recover_tec", bus.tec, 0);
      chk("recover_rec", bus.rec, 0);
      chk("recover_state", bus.err_state, 0);

      // CRC error + overload together, then WAIT timeout
      do_reset();
      bus.crc_err = 1; bus.ovrld_req = 1; tick(); clr();
      chk("both_rec", bus.rec, 1);
      chk("both_req", bus.f_ovrld, 0);
      chk("both_flag", bus.flag_passive, 0);
      tick();
      chk("both_single", bus.f_ovrld, 1);
      lows = 0;
      repeat (63) begin
         tick();
         if (bus.f_ovrld !== 1'b1) lows++;
      end
      chk("wait_no_pulse", lows[8:0], 0);
      bus.ovrld_req = 1; tick(); clr();
      chk("timeout_edge", bus.f_ovrld, 1);
      bus.ovrld_req = 1; tick(); clr();
      chk("after_timeout", bus.f_ovrld, 0);
      chk("ovrld_flag", bus.flag_passive, 0);

      // asynchronous reset mid-request and mid-WAIT
      #3 reset = 1;
      #1;
      chk("areset_req_f_ovrld", bus.f_ovrld, 1);
      tick();
      reset = 0;
      tick();
      chk("areset_no_pulse", bus.f_ovrld, 1);
      bus.tx_mode = 1; bus.bit_err = 1; tick(); clr();
      tick();
      bus.bit_err = 1; tick(); clr();
      chk("wait_tec", bus.tec, 16);
      #3 reset = 1;
      #1;
      chk("areset_f_ovrld", bus.f_ovrld, 1);
      chk("areset_tec", bus.tec, 0);
      chk("areset_rec", bus.rec, 0);
      chk("areset_flag", bus.flag_passive, 0);
      chk("areset_state", bus.err_state, 0);
      chk("areset_bus_off", bus.bus_off, 0);
      tick();
      reset = 0;
      tick();
      chk("areset_wait_no_pulse", bus.f_ovrld, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
